// File: rtl/thermal_monitor_ctrl_pkg.sv
// Shared definitions for the thermal monitor: FSM state encoding and default
// thresholds/sizes used by the controller and its debounce front end.
package thermal_monitor_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    LEER    = 2'b01,
    DECIDIR = 2'b10,
    ALERTA  = 2'b11
  } estado_t;

  localparam int N_CH_DEF       = 4;
  localparam int TEMP_W_DEF     = 6;
  localparam int DEB_CYCLES_DEF = 4;
  localparam int T_VENT_DEF     = 30;
  localparam int T_ALARM_DEF    = 45;
  localparam int HYST_DEF       = 2;

  // Channel index width, never narrower than one bit.
  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/thermal_monitor_ctrl_reg_antirebote_p.sv
// Vector synchronizer + debouncer: two flops into the clock domain, then the
// debounced vector follows only after DEB_CYCLES identical consecutive samples.
module reg_antirebote_p #(
  parameter int WIDTH      = 8,
  parameter int DEB_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             cambio
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [WIDTH-1:0] samp_p2;
  logic [CNT_W-1:0] cnt_p2;
  logic [CNT_W-1:0] run_nxt;
  logic             upd;

  // Run length of the current synchronized sample, saturating at DEB_CYCLES.
  always_comb begin
    run_nxt = cnt_p2;
    if (sync_p1 != samp_p2) begin
      run_nxt = CNT_W'(1);
    end else if (cnt_p2 < CNT_W'(DEB_CYCLES)) begin
      run_nxt = cnt_p2 + 1'b1;
    end
    upd = (sync_p1 != dout) && (run_nxt >= CNT_W'(DEB_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      samp_p2 <= '0;
      cnt_p2  <= '0;
      dout    <= '0;
      cambio  <= 1'b0;
    end else begin
      // p0/p1: synchronizer
      sync_p0 <= din;
      sync_p1 <= sync_p0;
      // p2: stability tracking and acceptance
      samp_p2 <= sync_p1;
      cnt_p2  <= run_nxt;
      cambio  <= upd;
      if (upd) begin
        dout <= sync_p1;
      end
    end
  end

endmodule

// File: rtl/thermal_monitor_ctrl.sv
// Thermal monitor controller: debounced channel maximum drives a ventilation/alarm FSM.
// Optional build macro ALARM_LATCH_EN keeps the alarm latched until acknowledged.
module thermal_monitor_ctrl
  import thermal_monitor_ctrl_pkg::*;
#(
  parameter int  N_CH       = N_CH_DEF,
  parameter int  TEMP_W     = TEMP_W_DEF,
  parameter int  DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int  T_VENT     = T_VENT_DEF,
  parameter int  T_ALARM    = T_ALARM_DEF,
  parameter int  HYST       = HYST_DEF,
  localparam int CH_W       = ch_idx_w(N_CH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*TEMP_W-1:0] temp_in,
  input  logic                   presencia,
  input  logic                   ignicion,
  input  logic                   alarm_ack,
  output logic                   ventilacion,
  output logic                   alarma,
  output logic [1:0]             estado,
  output logic [TEMP_W-1:0]      max_temp,
  output logic [CH_W-1:0]        max_ch,
  output logic                   dato_listo
);

  localparam int IN_W = N_CH * TEMP_W + 2;

`ifdef ALARM_LATCH_EN
  localparam bit ALARM_LATCH = 1'b1;
`else
  localparam bit ALARM_LATCH = 1'b0;
`endif

  // One extra bit so thresholds never wrap against the top reading code.
  localparam logic [TEMP_W:0] VENT_ON   = (TEMP_W + 1)'(T_VENT);
  localparam logic [TEMP_W:0] VENT_OFF  = (TEMP_W + 1)'(T_VENT - HYST);
  localparam logic [TEMP_W:0] ALARM_ON  = (TEMP_W + 1)'(T_ALARM);
  localparam logic [TEMP_W:0] ALARM_OFF = (TEMP_W + 1)'(T_ALARM - HYST);

  function automatic logic ge_thr(input logic [TEMP_W-1:0] v, input logic [TEMP_W:0] thr);
    return {1'b0, v} >= thr;
  endfunction

  function automatic logic lt_thr(input logic [TEMP_W-1:0] v, input logic [TEMP_W:0] thr);
    return {1'b0, v} < thr;
  endfunction

  logic [IN_W-1:0]        raw_vec;
  logic [IN_W-1:0]        deb_vec;
  logic                   cambio;
  logic [N_CH*TEMP_W-1:0] deb_temp;
  logic                   deb_pres;
  logic                   deb_ign;

  assign raw_vec  = {ignicion, presencia, temp_in};
  assign deb_temp = deb_vec[N_CH*TEMP_W-1:0];
  assign deb_pres = deb_vec[N_CH*TEMP_W];
  assign deb_ign  = deb_vec[IN_W-1];

  reg_antirebote_p #(
    .WIDTH      (IN_W),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_antirebote (
    .clk    (clk),
    .rst    (rst),
    .din    (raw_vec),
    .dout   (deb_vec),
    .cambio (cambio)
  );

  assign dato_listo = cambio;

  // Maximum over debounced channels; strict compare keeps the lowest index on ties.
  logic [TEMP_W-1:0] max_c;
  logic [CH_W-1:0]   ch_c;

  always_comb begin
    max_c = '0;
    ch_c  = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (deb_temp[k*TEMP_W +: TEMP_W] > max_c) begin
        max_c = deb_temp[k*TEMP_W +: TEMP_W];
        ch_c  = CH_W'(k);
      end
    end
  end

  estado_t           state_p0;
  estado_t           state_nxt;
  logic              load;
  logic [TEMP_W-1:0] max_nxt;
  logic [CH_W-1:0]   ch_nxt;
  logic              vent_nxt;
  logic              alarma_nxt;
  logic              demand;

  assign demand = deb_pres || deb_ign;

  always_comb begin
    state_nxt = state_p0;
    load      = 1'b0;
    case (state_p0)
      IDLE: begin
        state_nxt = LEER;
      end
      LEER: begin
        if (cambio) begin
          state_nxt = DECIDIR;
        end
      end
      DECIDIR: begin
        load      = 1'b1;
        state_nxt = ge_thr(max_c, ALARM_ON) ? ALERTA : LEER;
      end
      ALERTA: begin
        load = cambio;
        if (lt_thr(max_temp, ALARM_OFF)) begin
          state_nxt = LEER;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Ventilation is re-evaluated whenever a new maximum is captured, so it
  // becomes valid together with max_temp.
  always_comb begin
    max_nxt  = max_temp;
    ch_nxt   = max_ch;
    vent_nxt = ventilacion;
    if (load) begin
      max_nxt = max_c;
      ch_nxt  = ch_c;
      if (ge_thr(max_c, VENT_ON) && demand) begin
        vent_nxt = 1'b1;
      end else if (lt_thr(max_c, VENT_OFF) || !demand) begin
        vent_nxt = 1'b0;
      end
    end
    alarma_nxt = (state_nxt == ALERTA) ||
                 (ALARM_LATCH && alarma && !(alarm_ack && (state_p0 != ALERTA)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0    <= IDLE;
      max_temp    <= '0;
      max_ch      <= '0;
      ventilacion <= 1'b0;
      alarma      <= 1'b0;
    end else begin
      state_p0    <= state_nxt;
      max_temp    <= max_nxt;
      max_ch      <= ch_nxt;
      ventilacion <= vent_nxt;
      alarma      <= alarma_nxt;
    end
  end

  assign estado = state_p0;

endmodule
